// File: rtl/cordic_rot_iter_stage.sv
// Iterative CORDIC rotation engine (rotation mode) on a single shared datapath.
// Takes a pre-rotated X/Y pair plus residual angle Z, runs ITER shift-add
// micro-rotations (one per enabled clock), then holds the result on a
// valid/ready output until the downstream scaling stage accepts it.
//
// Ports:
//   C, RSTN              clock (rising edge), asynchronous active-low reset
//   CE                   clock enable; all state and outputs freeze when low
//   in_valid / in_ready  upstream handshake for x_in, y_in, z_in
//   x_in, y_in           signed W-bit vector from the pre-rotation stage
//   z_in                 signed AW-bit residual angle, full circle = 2^AW
//   out_valid/out_ready  downstream handshake for x_out, y_out, z_out
//   x_out, y_out         rotated vector, scaled by the CORDIC gain
//   z_out                residual angle left after the last micro-rotation
//
// The arctangent ROM is stored at 32-bit angle resolution and rescaled with
// rounding to AW bits; AW is limited to 64.
module cordic_rot_iter_stage #(
  parameter int unsigned W    = 32,
  parameter int unsigned AW   = 32,
  parameter int unsigned ITER = 16
) (
  input  logic                 C,
  input  logic                 RSTN,
  input  logic                 CE,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [W-1:0]  x_in,
  input  logic signed [W-1:0]  y_in,
  input  logic signed [AW-1:0] z_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [W-1:0]  x_out,
  output logic signed [W-1:0]  y_out,
  output logic signed [AW-1:0] z_out
);

  localparam int unsigned IW  = (ITER > 1) ? $clog2(ITER) : 1;
  localparam int unsigned SHL = (AW > 32) ? AW - 32 : 32'd0;
  localparam int unsigned SHR = (AW < 32) ? 32 - AW : 32'd0;
  localparam logic [63:0] RND = (64'd1 << SHR) >> 1;
  localparam logic [IW-1:0] I_LAST = IW'(ITER - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [IW-1:0]       i_q, i_d;
  logic signed [W-1:0] x_q, x_d, y_q, y_d;
  logic signed [AW-1:0] z_q, z_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;

  logic [5:0]           rom_idx_c;
  logic [31:0]          atan32_c;
  logic signed [AW-1:0] atan_c;
  logic signed [W-1:0]  x_sh_c, y_sh_c;

  // atan(2^-i) in units of 2^-32 of a full circle, rounded to nearest
  assign rom_idx_c = 6'(i_q);
  always_comb begin
    atan32_c = 32'd0;
    case (rom_idx_c)
      6'd0:  atan32_c = 32'h2000_0000;
      6'd1:  atan32_c = 32'h12E4_051E;
      6'd2:  atan32_c = 32'h09FB_385B;
      6'd3:  atan32_c = 32'h0511_11D4;
      6'd4:  atan32_c = 32'h028B_0D43;
      6'd5:  atan32_c = 32'h0145_D7E1;
      6'd6:  atan32_c = 32'h00A2_F61E;
      6'd7:  atan32_c = 32'h0051_7C55;
      6'd8:  atan32_c = 32'h0028_BE53;
      6'd9:  atan32_c = 32'h0014_5F2F;
      6'd10: atan32_c = 32'h000A_2F98;
      6'd11: atan32_c = 32'h0005_17CC;
      6'd12: atan32_c = 32'h0002_8BE6;
      6'd13: atan32_c = 32'h0001_45F3;
      6'd14: atan32_c = 32'h0000_A2FA;
      6'd15: atan32_c = 32'h0000_517D;
      6'd16: atan32_c = 32'h0000_28BE;
      6'd17: atan32_c = 32'h0000_145F;
      6'd18: atan32_c = 32'h0000_0A30;
      6'd19: atan32_c = 32'h0000_0518;
      6'd20: atan32_c = 32'h0000_028C;
      6'd21: atan32_c = 32'h0000_0146;
      6'd22: atan32_c = 32'h0000_00A3;
      6'd23: atan32_c = 32'h0000_0051;
      6'd24: atan32_c = 32'h0000_0029;
      6'd25: atan32_c = 32'h0000_0014;
      6'd26: atan32_c = 32'h0000_000A;
      6'd27: atan32_c = 32'h0000_0005;
      6'd28: atan32_c = 32'h0000_0003;
      6'd29: atan32_c = 32'h0000_0001;
      6'd30: atan32_c = 32'h0000_0001;
      default: atan32_c = 32'd0;
    endcase
  end

  // Rescale the 32-bit-circle ROM word to AW bits (round-half-up when narrowing)
  assign atan_c = AW'(((64'(atan32_c) << SHL) + RND) >> SHR);

  // Arithmetic right shifts of the pre-update vector
  assign x_sh_c = x_q >>> i_q;
  assign y_sh_c = y_q >>> i_q;

  // Next-state, datapath and handshake flags
  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    x_d         = x_q;
    y_d         = y_q;
    z_d         = z_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          x_d        = x_in;
          y_d        = y_in;
          z_d        = z_in;
          i_d        = '0;
          in_ready_d = 1'b0;
          state_d    = S_RUN;
        end
      end
      S_RUN: begin
        // Rotate toward z = 0: d = +1 when z >= 0, else -1
        if (z_q[AW-1]) begin
          x_d = x_q + y_sh_c;
          y_d = y_q - x_sh_c;
          z_d = z_q + atan_c;
        end else begin
          x_d = x_q - y_sh_c;
          y_d = y_q + x_sh_c;
          z_d = z_q - atan_c;
        end
        if (i_q == I_LAST) begin
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          i_d = i_q + IW'(1);
        end
      end
      S_DONE: begin
        // Input is never taken here, which forces one IDLE bubble between results
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  // State register, frozen while CE is low
  always_ff @(posedge C or negedge RSTN) begin
    if (!RSTN) begin
      state_q     <= S_IDLE;
      i_q         <= '0;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else if (CE) begin
      state_q     <= state_d;
      i_q         <= i_d;
      x_q         <= x_d;
      y_q         <= y_d;
      z_q         <= z_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign x_out     = x_q;
  assign y_out     = y_q;
  assign z_out     = z_q;

endmodule

// File: tb/tb_cordic_rot_iter_stage.sv
// Self-checking bench for cordic_rot_iter_stage: table of directed vectors,
// randomized vectors against a bit-true model plus an ideal real-math rotation,
// and hand-written handshake / CE / reset sequences.
module tb_cordic_rot_iter_stage;

  localparam int ITER = 16;
  localparam real PI  = 3.14159265358979323846;
  localparam real TWO32 = 4294967296.0;

  logic C = 1'b0;
  logic RSTN, CE, in_valid, in_ready, out_valid, out_ready;
  logic signed [31:0] x_in, y_in, z_in, x_out, y_out, z_out;

  always #5 C = ~C;

  cordic_rot_iter_stage #(.W(32), .AW(32), .ITER(ITER)) dut (
    .C(C), .RSTN(RSTN), .CE(CE),
    .in_valid(in_valid), .in_ready(in_ready),
    .x_in(x_in), .y_in(y_in), .z_in(z_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .x_out(x_out), .y_out(y_out), .z_out(z_out)
  );

  typedef struct {
    logic signed [31:0] x, y, z;
    int stall_at;
    int hold;
    logic signed [31:0] ex, ey, ez;
  } vec_t;

  int checks = 0;
  int errors = 0;
  logic signed [31:0] atan_tab [ITER];
  real k_gain;
  vec_t vecs [4];

  task automatic tick;
    @(posedge C);
    #1;
  endtask

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic chk_near(input string nm, input longint act, input real exp, input real tol);
    real d;
    checks++;
    d = real'(act) - exp;
    if (d < 0.0) d = -d;
    if (d > tol) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0.1f tol=%0.1f", nm, act, exp, tol);
    end
  endtask

  // Bit-true rotation-mode CORDIC written straight from the micro-rotation rule
  function automatic void cordic_model(input logic signed [31:0] xi, yi, zi,
                                       output logic signed [31:0] xo, yo, zo);
    logic signed [31:0] x, y, z, xn, yn;
    x = xi; y = yi; z = zi;
    for (int i = 0; i < ITER; i++) begin
      if (z >= 0) begin
        xn = x - (y >>> i); yn = y + (x >>> i); z = z - atan_tab[i];
      end else begin
        xn = x + (y >>> i); yn = y - (x >>> i); z = z + atan_tab[i];
      end
      x = xn; y = yn;
    end
    xo = x; yo = y; zo = z;
  endfunction

  function automatic vec_t mk(input logic signed [31:0] x, y, z, input int stall_at, hold);
    vec_t v;
    v.x = x; v.y = y; v.z = z; v.stall_at = stall_at; v.hold = hold;
    cordic_model(x, y, z, v.ex, v.ey, v.ez);
    return v;
  endfunction

  task automatic run_vec(input string tag, input vec_t v);
    int n, lat;
    real th, ix, iy;
    n = 0;
    while (!in_ready && n < 50) begin tick(); n++; end
    chk({tag, "_rdy_pre"}, in_ready, 1);
    x_in = v.x; y_in = v.y; z_in = v.z; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk({tag, "_rdy_busy"}, in_ready, 0);
    lat = 0;
    while (!out_valid && lat < 200) begin
      if (lat == v.stall_at) begin
        CE = 1'b0;
        repeat (3) tick();
        lat += 3;
        CE = 1'b1;
      end
      tick();
      lat++;
    end
    chk({tag, "_latency"}, lat, ITER + ((v.stall_at >= 0) ? 3 : 0));
    chk({tag, "_x"}, x_out, v.ex);
    chk({tag, "_y"}, y_out, v.ey);
    chk({tag, "_z"}, z_out, v.ez);
    // Ideal rotation by the angle actually consumed, scaled by the CORDIC gain
    th = real'(longint'(v.z) - longint'(v.ez)) * 2.0 * PI / TWO32;
    ix = k_gain * (real'(v.x) * $cos(th) - real'(v.y) * $sin(th));
    iy = k_gain * (real'(v.x) * $sin(th) + real'(v.y) * $cos(th));
    chk_near({tag, "_x_ideal"}, x_out, ix, 128.0);
    chk_near({tag, "_y_ideal"}, y_out, iy, 128.0);
    if (v.hold > 0) begin
      repeat (v.hold) tick();
      chk({tag, "_hold_valid"}, out_valid, 1);
      chk({tag, "_hold_x"}, x_out, v.ex);
      chk({tag, "_hold_y"}, y_out, v.ey);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_valid_drop"}, out_valid, 0);
    chk({tag, "_rdy_post"}, in_ready, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n, lat, seen;
    vec_t va, vb, vr;
    logic signed [31:0] rx, ry, rz;

    for (int i = 0; i < ITER; i++)
      atan_tab[i] = 32'(longint'($atan($pow(2.0, real'(-i))) * TWO32 / (2.0 * PI)));
    k_gain = 1.0;
    for (int i = 0; i < ITER; i++) k_gain = k_gain * $sqrt(1.0 + $pow(2.0, -2.0 * real'(i)));

    vecs[0] = mk(32'sh1000_0000, 32'sd0, 32'sd0, -1, 10);
    vecs[1] = mk(32'sh1000_0000, 32'sd0, 32'sh2000_0000, -1, 0);
    vecs[2] = mk(32'sh1000_0000, 32'sd0, -32'sd715827883, -1, 0);
    vecs[3] = mk(32'sh0C00_0000, 32'sh0300_0000, 32'sh1555_5555, 5, 2);

    RSTN = 1'b0; CE = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    x_in = '0; y_in = '0; z_in = '0;
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_x", x_out, 0);
    chk("rst_y", y_out, 0);
    chk("rst_z", z_out, 0);
    @(negedge C) RSTN = 1'b1;
    tick();

    // CE low in IDLE: a presented word must not be taken
    CE = 1'b0; in_valid = 1'b1; x_in = 32'sh0100_0000;
    repeat (3) tick();
    chk("ce_idle_rdy", in_ready, 1);
    chk("ce_idle_x", x_out, 0);
    in_valid = 1'b0; CE = 1'b1;

    for (int k = 0; k < 4; k++) run_vec($sformatf("vec%0d", k), vecs[k]);

    // Zero-angle bounds on the residual Y and Z
    chk_near("zero_y_bound", longint'(vecs[0].ey), 0.0, 65536.0 + 64.0);
    chk_near("zero_z_bound", longint'(vecs[0].ez), 0.0, real'(atan_tab[15]));

    // Busy input ignored, CE hold in DONE, then back-to-back with one bubble
    va = mk(32'sh0800_0000, -32'sh0400_0000, -32'sh1234_5678, -1, 0);
    vb = mk(-32'sh0600_0000, 32'sh0200_0000, 32'sh3000_0000, -1, 0);
    n = 0;
    while (!in_ready && n < 50) begin tick(); n++; end
    x_in = va.x; y_in = va.y; z_in = va.z; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    chk("busy_rdy", in_ready, 0);
    x_in = vb.x; y_in = vb.y; z_in = vb.z; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin tick(); n++; end
    chk("busy_done", out_valid, 1);
    chk("busy_x", x_out, va.ex);
    chk("busy_y", y_out, va.ey);
    chk("busy_z", z_out, va.ez);
    CE = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
    repeat (2) tick();
    chk("ce_done_valid", out_valid, 1);
    chk("ce_done_rdy", in_ready, 0);
    CE = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("b2b_valid_drop", out_valid, 0);
    chk("b2b_bubble_rdy", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("b2b_accept", in_ready, 0);
    lat = 0;
    while (!out_valid && lat < 200) begin tick(); lat++; end
    chk("b2b_latency", lat, ITER);
    chk("b2b_x", x_out, vb.ex);
    chk("b2b_y", y_out, vb.ey);
    chk("b2b_z", z_out, vb.ez);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Asynchronous reset at iteration 7 aborts the operation
    x_in = va.x; y_in = va.y; z_in = va.z; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (7) tick();
    #2 RSTN = 1'b0;
    #1;
    chk("abort_x", x_out, 0);
    chk("abort_y", y_out, 0);
    chk("abort_z", z_out, 0);
    chk("abort_valid", out_valid, 0);
    chk("abort_rdy", in_ready, 1);
    @(negedge C) RSTN = 1'b1;
    seen = 0;
    repeat (ITER + 5) begin
      tick();
      if (out_valid) seen++;
    end
    chk("abort_no_valid", seen, 0);
    chk("abort_rdy_after", in_ready, 1);

    // Randomized vectors
    for (int r = 0; r < 24; r++) begin
      rx = 32'($urandom_range(0, 32'h1FFF_FFFF)) - 32'sh1000_0000;
      ry = 32'($urandom_range(0, 32'h1FFF_FFFF)) - 32'sh1000_0000;
      rz = 32'($urandom_range(0, 32'h7FFF_FFFE)) - 32'sh3FFF_FFFF;
      vr = mk(rx, ry, rz, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, ITER - 1)) : -1,
              int'($urandom_range(0, 2)));
      run_vec($sformatf("rnd%0d", r), vr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
